// File: rtl/bsr_frame_if.sv
// bsr_frame_if: requester handshake, serial link and receive-word bundle for bsr_frame_ctrl
//   req_valid/req_ready/req_dir/req_data : parallel frame request handshake
//   abort                                : terminate the frame in flight
//   sin/sout/sout_valid                  : serial link, one bit per cycle
//   busy                                 : controller not idle
//   rx_data/rx_valid                     : received word and its one-cycle pulse
// master = requester/link side, slave = controller side.
interface bsr_frame_if #(parameter int WIDTH = 4);
    logic             req_valid;
    logic             req_ready;
    logic             req_dir;
    logic [WIDTH-1:0] req_data;
    logic             abort;
    logic             sin;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    modport master (
        output req_valid, req_dir, req_data, abort, sin,
        input  req_ready, sout, sout_valid, busy, rx_data, rx_valid
    );
    modport slave (
        input  req_valid, req_dir, req_data, abort, sin,
        output req_ready, sout, sout_valid, busy, rx_data, rx_valid
    );
endinterface

// File: rtl/bsr_frame_ctrl.sv
// bsr_frame_ctrl: serialises a parallel word MSB- or LSB-first while capturing the serial input
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : bsr_frame_if slave (request handshake, abort, serial link, received word)
// The idle cycle in which the next frame is accepted counts as one of the GAP idle
// cycles, so only GAP-1 cycles are spent in the GAP state. With GAP=0 the next frame
// is accepted on the last bit of the current one, giving contiguous frames.
module bsr_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input logic       clk,
    input logic       rst,
    bsr_frame_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             dir;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             last;
    logic             chain;
    logic             accept;
    assign last    = (state == S_SHIFT) && (bit_cnt == BW'(WIDTH - 1));
    // chaining only exists without a gap; an abort on the last bit cancels it
    assign chain   = (GAP == 0) && last && !bus.abort;
    assign accept  = bus.req_valid && bus.req_ready;
    assign shifted = dir ? {sr[WIDTH-2:0], bus.sin} : {bus.sin, sr[WIDTH-1:1]};
    assign bus.req_ready  = (state == S_IDLE) || chain;
    assign bus.sout       = dir ? sr[WIDTH-1] : sr[0];
    assign bus.sout_valid = state == S_SHIFT;
    assign bus.busy       = state != S_IDLE;
    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            sr       <= '0;
            dir      <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state != S_IDLE && bus.abort) begin
                state   <= S_IDLE;
                sr      <= '0;
                bit_cnt <= '0;
                gap_cnt <= '0;
            end else if (accept) begin
                // a chained accept also completes the frame in flight
                if (last) begin
                    rx_data  <= shifted;
                    rx_valid <= 1'b1;
                end
                state   <= S_SHIFT;
                sr      <= bus.req_data;
                dir     <= bus.req_dir;
                bit_cnt <= '0;
            end else if (state == S_SHIFT) begin
                sr <= shifted;
                if (last) begin
                    rx_data  <= shifted;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                    gap_cnt  <= '0;
                    state    <= (GAP > 1) ? S_GAP : S_IDLE;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (state == S_GAP) begin
                if (gap_cnt == GW'(GAP - 2)) begin
                    state   <= S_IDLE;
                    gap_cnt <= '0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bsr_frame_ctrl.sv
// tb_bsr_frame_ctrl: directed bench for bsr_frame_ctrl with WIDTH=4, GAP=1 and a GAP=0 instance
module tb_bsr_frame_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    bsr_frame_if #(.WIDTH(4)) b0();
    bsr_frame_if #(.WIDTH(4)) b1();
    bsr_frame_ctrl #(.WIDTH(4), .GAP(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    bsr_frame_ctrl #(.WIDTH(4), .GAP(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // drives one frame on b0; so holds the serial bits with the first one at [3]
    task automatic send(input logic [3:0] data, input logic d, input logic [3:0] sins,
                        input int abort_at, input logic loop, input logic hold,
                        output logic [3:0] so, output int vcnt, output int rdy_cnt);
        int n = 0;
        so = '0;
        vcnt = 0;
        rdy_cnt = 0;
        b0.req_data  = data;
        b0.req_dir   = d;
        b0.req_valid = 1'b1;
        while (!b0.req_ready && n < 8) begin
            tick();
            n++;
        end
        if (!b0.req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready got 0 want 1");
            b0.req_valid = 1'b0;
            return;
        end
        tick();
        b0.req_valid = hold;
        b0.req_data  = ~data;
        b0.req_dir   = ~d;
        for (int k = 0; k < 4; k++) begin
            so[3-k] = b0.sout;
            if (b0.sout_valid) vcnt++;
            if (b0.req_ready) rdy_cnt++;
            b0.sin   = loop ? b0.sout : sins[3-k];
            b0.abort = (k == abort_at);
            tick();
            b0.abort = 1'b0;
            if (k == abort_at) break;
        end
        b0.req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", b0.busy); end
        checks++; if (b0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", b0.req_ready); end
        checks++; if (b0.sout_valid !== 1'b0 || b0.sout !== 1'b0) begin errors++; $display("FAIL rst_sout got %b%b want 00", b0.sout_valid, b0.sout); end
        checks++; if (b0.rx_valid !== 1'b0 || b0.rx_data !== 4'h0) begin errors++; $display("FAIL rst_rx got %b/%h want 0/0", b0.rx_valid, b0.rx_data); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (b0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", b0.req_ready); end
    endtask

    task automatic test_left;
        logic [3:0] so;
        int vc, rc;
        send(4'b1010, 1'b1, 4'b0110, 4, 1'b0, 1'b0, so, vc, rc);
        checks++; if (so !== 4'b1010) begin errors++; $display("FAIL left_sout got %b want 1010", so); end
        checks++; if (vc !== 4) begin errors++; $display("FAIL left_valid_cycles got %0d want 4", vc); end
        checks++; if (b0.rx_valid !== 1'b1 || b0.rx_data !== 4'b0110) begin errors++; $display("FAIL left_rx got %b/%b want 1/0110", b0.rx_valid, b0.rx_data); end
        tick();
        checks++; if (b0.rx_valid !== 1'b0 || b0.rx_data !== 4'b0110) begin errors++; $display("FAIL left_rx_pulse got %b/%b want 0/0110", b0.rx_valid, b0.rx_data); end
    endtask

    task automatic test_right;
        logic [3:0] so;
        int vc, rc;
        send(4'b1001, 1'b0, 4'b1100, 4, 1'b0, 1'b0, so, vc, rc);
        checks++; if (so !== 4'b1001) begin errors++; $display("FAIL right_sout got %b want 1001", so); end
        checks++; if (b0.rx_valid !== 1'b1 || b0.rx_data !== 4'b0011) begin errors++; $display("FAIL right_rx got %b/%b want 1/0011", b0.rx_valid, b0.rx_data); end
        tick();
        checks++; if (b0.rx_valid !== 1'b0) begin errors++; $display("FAIL right_rx_pulse got %b want 0", b0.rx_valid); end
    endtask

    task automatic test_reset_mid;
        b0.req_data  = 4'b1010;
        b0.req_dir   = 1'b1;
        b0.req_valid = 1'b1;
        tick();
        b0.req_valid = 1'b0;
        tick();
        checks++; if (b0.sout_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b want 1", b0.sout_valid); end
        rst = 1'b0;
        #1;
        checks++; if (b0.sout_valid !== 1'b0 || b0.busy !== 1'b0) begin errors++; $display("FAIL midrst_state got %b%b want 00", b0.sout_valid, b0.busy); end
        checks++; if (b0.rx_valid !== 1'b0 || b0.rx_data !== 4'h0) begin errors++; $display("FAIL midrst_rx got %b/%b want 0/0000", b0.rx_valid, b0.rx_data); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (b0.req_ready !== 1'b1 || b0.busy !== 1'b0) begin errors++; $display("FAIL midrst_release got %b%b want 10", b0.req_ready, b0.busy); end
    endtask

    task automatic test_abort;
        logic [3:0] so;
        int vc, rc;
        send(4'b0110, 1'b0, 4'b1010, 4, 1'b0, 1'b0, so, vc, rc);
        checks++; if (b0.rx_data !== 4'b0101) begin errors++; $display("FAIL abort_setup_rx got %b want 0101", b0.rx_data); end
        for (int a = 2; a <= 3; a++) begin
            send(4'b1111, 1'b1, 4'b0000, a, 1'b0, 1'b0, so, vc, rc);
            checks++; if (vc !== a + 1) begin errors++; $display("FAIL abort%0d_valid_cycles got %0d want %0d", a, vc, a + 1); end
            checks++; if (b0.sout_valid !== 1'b0 || b0.busy !== 1'b0 || b0.req_ready !== 1'b1) begin errors++; $display("FAIL abort%0d_state got v%b b%b r%b want v0 b0 r1", a, b0.sout_valid, b0.busy, b0.req_ready); end
            checks++; if (b0.rx_valid !== 1'b0 || b0.rx_data !== 4'b0101) begin errors++; $display("FAIL abort%0d_rx got %b/%b want 0/0101", a, b0.rx_valid, b0.rx_data); end
            tick();
            checks++; if (b0.rx_valid !== 1'b0) begin errors++; $display("FAIL abort%0d_rx_late got %b want 0", a, b0.rx_valid); end
        end
        b0.abort     = 1'b1;
        b0.req_valid = 1'b1;
        b0.req_data  = 4'b1000;
        b0.req_dir   = 1'b1;
        tick();
        b0.abort     = 1'b0;
        b0.req_valid = 1'b0;
        checks++; if (b0.sout_valid !== 1'b1 || b0.sout !== 1'b1) begin errors++; $display("FAIL abort_idle got v%b s%b want v1 s1", b0.sout_valid, b0.sout); end
        repeat (4) tick();
        checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_done got %b want 0", b0.busy); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] pat;
        int acc = 0;
        int rxc = 0;
        b0.req_data  = 4'b1100;
        b0.req_dir   = 1'b1;
        b0.sin       = 1'b1;
        b0.req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (b0.req_valid && b0.req_ready) acc++;
            tick();
            if (acc == 2) b0.req_valid = 1'b0;
            pat[9-c] = b0.sout_valid;
            if (b0.rx_valid) rxc++;
        end
        checks++; if (pat !== 10'b1111011110) begin errors++; $display("FAIL b2b_gap1 got %b want 1111011110", pat); end
        checks++; if (rxc !== 2 || b0.rx_data !== 4'b1111) begin errors++; $display("FAIL b2b_gap1_rx got %0d/%b want 2/1111", rxc, b0.rx_data); end
        acc = 0;
        rxc = 0;
        pat = '0;
        b1.req_data  = 4'b1100;
        b1.req_dir   = 1'b1;
        b1.sin       = 1'b1;
        b1.req_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (b1.req_valid && b1.req_ready) acc++;
            tick();
            if (acc == 2) b1.req_valid = 1'b0;
            pat[8-c] = b1.sout_valid;
            if (b1.rx_valid) rxc++;
        end
        checks++; if (pat[8:0] !== 9'b111111110) begin errors++; $display("FAIL b2b_gap0 got %b want 111111110", pat[8:0]); end
        checks++; if (rxc !== 2 || b1.rx_data !== 4'b1111) begin errors++; $display("FAIL b2b_gap0_rx got %0d/%b want 2/1111", rxc, b1.rx_data); end
    endtask

    task automatic test_loopback;
        logic [3:0] so, data, exp_so;
        logic d;
        int vc, rc;
        for (int i = 0; i < 50; i++) begin
            data = 4'($urandom_range(0, 15));
            d    = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) exp_so[k] = d ? data[k] : data[3-k];
            send(data, d, 4'b0000, 4, 1'b1, 1'b1, so, vc, rc);
            checks++; if (b0.rx_valid !== 1'b1 || b0.rx_data !== data) begin errors++; $display("FAIL loop%0d_rx got %b/%b want 1/%b", i, b0.rx_valid, b0.rx_data, data); end
            checks++; if (so !== exp_so || vc !== 4) begin errors++; $display("FAIL loop%0d_sout got %b/%0d want %b/4", i, so, vc, exp_so); end
            checks++; if (rc !== 0) begin errors++; $display("FAIL loop%0d_busy_ready got %0d want 0", i, rc); end
        end
    endtask

    initial begin
        {b0.req_valid, b0.req_dir, b0.req_data, b0.abort, b0.sin} = '0;
        {b1.req_valid, b1.req_dir, b1.req_data, b1.abort, b1.sin} = '0;
        test_reset();
        test_left();
        test_right();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
